// File: rtl/shift_reg_proc.sv
`default_nettype none
// ============================================================================
// shift_reg_proc : WIDTH-bit universal register / shifter with multi-step rotate
// Optional macro SHIFT_REG_PARITY_EN adds a registered even-parity output.
// Revision 1.0
// ============================================================================
module shift_reg_proc #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  parameter int               AMT_W      = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             preset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
`ifdef SHIFT_REG_PARITY_EN
  output logic             parity,
`endif
  output logic             done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_MULTI = 3'b110;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (preset) begin
      shreg_d = PRESET_VAL;
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = dir_q ? {shreg_q[0], shreg_q[WIDTH-1:1]}
                      : {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
      cnt_d   = cnt_q - AMT_W'(1);
      if (cnt_q == AMT_W'(1)) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end else if (en) begin
      case (mode)
        MODE_LOAD: shreg_d = d;
        MODE_SHL:  shreg_d = {shreg_q[WIDTH-2:0], sin_l};
        MODE_SHR:  shreg_d = {sin_r, shreg_q[WIDTH-1:1]};
        MODE_ROL:  shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
        MODE_ROR:  shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
        MODE_MULTI: begin
          // A zero count completes instantly: done pulses but SHIFT is never entered.
          if (amt != '0) begin
            cnt_d   = amt;
            dir_d   = dir;
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
        MODE_HOLD: shreg_d = shreg_q;
        default:   shreg_d = shreg_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SHIFT_REG_PARITY_EN
  logic parity_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^shreg_d;
    end
  end

  assign parity = parity_q;
`endif

  assign q      = shreg_q;
  assign sout_l = shreg_q[WIDTH-1];
  assign sout_r = shreg_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_proc.sv
`default_nettype none
// ============================================================================
// tb_shift_reg_proc : directed self-checking bench for shift_reg_proc (WIDTH=8)
// Revision 1.0
// ============================================================================
module tb_shift_reg_proc;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clock;
  logic             clear;
  logic             preset;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [AMT_W-1:0] amt;
  logic             dir;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
`ifdef SHIFT_REG_PARITY_EN
  logic             parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  shift_reg_proc #(
    .WIDTH      (WIDTH),
    .PRESET_VAL (8'hFF),
    .AMT_W      (AMT_W)
  ) u_dut (
    .clock  (clock),
    .clear  (clear),
    .preset (preset),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .amt    (amt),
    .dir    (dir),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
`ifdef SHIFT_REG_PARITY_EN
    .parity (parity),
`endif
    .done   (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] val);
    en   = 1'b1;
    mode = 3'b001;
    d    = val;
    step();
    mode = 3'b000;
  endtask

  initial begin
    clear = 1'b1; preset = 1'b0; en = 1'b0; mode = 3'b000; d = '0;
    sin_l = 1'b0; sin_r = 1'b0; amt = '0; dir = 1'b0;
    step();
    step();
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    clear = 1'b0;

    // Asynchronous clear between edges
    load(8'hA5);
    chk("load_A5", 32'(q), 32'hA5);
    #3 clear = 1'b1;
    #1;
    chk("aclr_q_immediate", 32'(q), 32'h00);
    chk("aclr_busy", 32'(busy), 32'h0);
    chk("aclr_done", 32'(done), 32'h0);
    en = 1'b1; mode = 3'b001; d = 8'h5A;
    step();
    chk("aclr_hold", 32'(q), 32'h00);
    clear = 1'b0; mode = 3'b000;

    // Load then preset, preset has priority
    load(8'h3C);
    chk("load_3C", 32'(q), 32'h3C);
    preset = 1'b1; mode = 3'b001; d = 8'hFF;
    step();
    chk("preset_ff", 32'(q), 32'hFF);
    load(8'h3C);
    preset = 1'b1; mode = 3'b001; d = 8'h12;
    step();
    chk("preset_wins", 32'(q), 32'hFF);
    preset = 1'b0; mode = 3'b000;

    // Serial shifts and rotates
    load(8'h81);
    mode = 3'b010; sin_l = 1'b0;
    step();
    chk("shl_q", 32'(q), 32'h02);
    chk("shl_sout_l", 32'(sout_l), 32'h0);
    chk("shl_sout_r", 32'(sout_r), 32'h0);
    mode = 3'b011; sin_r = 1'b1;
    step();
    chk("shr_q", 32'(q), 32'h81);
    chk("shr_sout_l", 32'(sout_l), 32'h1);
    en = 1'b0; mode = 3'b010;
    step();
    chk("en0_hold", 32'(q), 32'h81);
    en = 1'b1; mode = 3'b100;
    step();
    chk("rol", 32'(q), 32'h03);
    mode = 3'b101;
    step();
    chk("ror", 32'(q), 32'h81);
    mode = 3'b111;
    step();
    chk("reserved_hold", 32'(q), 32'h81);

    // Multi-shift left by 3 with inputs toggled while busy
    load(8'h01);
    mode = 3'b110; amt = 4'd3; dir = 1'b0;
    step();
    chk("ms_start_q", 32'(q), 32'h01);
    chk("ms_start_busy", 32'(busy), 32'h1);
    mode = 3'b001; d = 8'hFF; dir = 1'b1; amt = 4'd0;
    step();
    chk("ms_1_q", 32'(q), 32'h02);
    chk("ms_1_busy", 32'(busy), 32'h1);
    chk("ms_1_done", 32'(done), 32'h0);
    step();
    chk("ms_2_q", 32'(q), 32'h04);
    chk("ms_2_busy", 32'(busy), 32'h1);
    mode = 3'b000;
    step();
    chk("ms_3_q", 32'(q), 32'h08);
    chk("ms_3_busy", 32'(busy), 32'h0);
    chk("ms_3_done", 32'(done), 32'h1);
    step();
    chk("ms_after_done", 32'(done), 32'h0);
    chk("ms_after_q", 32'(q), 32'h08);

    // Wrap: amt=9 rotate right from 0x01
    load(8'h01);
    mode = 3'b110; amt = 4'd9; dir = 1'b1;
    step();
    mode = 3'b000;
    for (int i = 0; i < 8; i++) step();
    chk("wrap_8_q", 32'(q), 32'h01);
    chk("wrap_8_busy", 32'(busy), 32'h1);
    step();
    chk("wrap_9_q", 32'(q), 32'h80);
    chk("wrap_9_busy", 32'(busy), 32'h0);
    chk("wrap_9_done", 32'(done), 32'h1);

    // Abort by preset on second cycle of a 5-step run
    load(8'h01);
    mode = 3'b110; amt = 4'd5; dir = 1'b0;
    step();
    mode = 3'b000;
    step();
    chk("abort_pre_q", 32'(q), 32'h02);
    preset = 1'b1;
    step();
    chk("abort_q", 32'(q), 32'hFF);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    preset = 1'b0;
    step();
    chk("abort_done_next", 32'(done), 32'h0);
    chk("abort_q_next", 32'(q), 32'hFF);

    // Zero-count start: done pulse only
    mode = 3'b110; amt = 4'd0;
    step();
    chk("amt0_busy", 32'(busy), 32'h0);
    chk("amt0_done", 32'(done), 32'h1);
    chk("amt0_q", 32'(q), 32'hFF);
    mode = 3'b000;
    step();
    chk("amt0_done_clr", 32'(done), 32'h0);

`ifdef SHIFT_REG_PARITY_EN
    load(8'h07);
    chk("par_07", 32'(parity), 32'h1);
    load(8'h03);
    chk("par_03", 32'(parity), 32'h0);
    load(8'h01);
    chk("par_01", 32'(parity), 32'h1);
    #3 clear = 1'b1;
    #1;
    chk("par_clear", 32'(parity), 32'h0);
    step();
    clear = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
